// File: rtl/trace_stream_serializer.sv
// Splits wide AXI-Stream trace packets into OUT_WIDTH beats, MSB slice first.
// Optional per-packet sequence header beat: define TRACE_SERIALIZER_SEQ_HEADER_EN.
module trace_stream_serializer #(
  parameter int IN_WIDTH  = 1024,
  parameter int OUT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 S_AXIS_tvalid,
  output logic                 S_AXIS_tready,
  input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
  input  logic                 S_AXIS_tlast,
  output logic                 M_AXIS_tvalid,
  input  logic                 M_AXIS_tready,
  output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
  output logic                 M_AXIS_tlast,
  output logic [31:0]          pkt_count,
  output logic                 busy
);

  localparam int BEATS = IN_WIDTH / OUT_WIDTH;
`ifdef TRACE_SERIALIZER_SEQ_HEADER_EN
  localparam int LAST = BEATS;
`else
  localparam int LAST = BEATS - 1;
`endif
  localparam int IDX_W = $clog2(BEATS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);

  generate
    if ((IN_WIDTH % OUT_WIDTH) != 0 || IN_WIDTH < OUT_WIDTH) begin : g_bad_width
      $error("IN_WIDTH must be an integer multiple of OUT_WIDTH");
    end
`ifdef TRACE_SERIALIZER_SEQ_HEADER_EN
    if (OUT_WIDTH <= 48) begin : g_bad_hdr_width
      $error("header beat needs OUT_WIDTH > 48");
    end
`endif
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IN_WIDTH-1:0]  sreg;
  logic [IDX_W-1:0]     idx;
  logic                 lflag;
  logic                 at_last;
  logic                 in_hs;
  logic                 out_hs;

`ifdef TRACE_SERIALIZER_SEQ_HEADER_EN
  logic [31:0]          seq;
  logic [31:0]          hdr_seq;
`endif

  assign busy    = (state == SEND);
  assign at_last = (idx == LAST_IDX);
  assign out_hs  = busy & M_AXIS_tready;
  // Final-beat term lets the next packet load in the cycle the last beat leaves.
  assign S_AXIS_tready = rst_n & ((state == IDLE) | (busy & at_last & M_AXIS_tready));
  assign in_hs   = S_AXIS_tvalid & S_AXIS_tready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_hs) state_nxt = SEND;
      SEND:    if (out_hs && at_last && !in_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    M_AXIS_tvalid = 1'b0;
    M_AXIS_tdata  = '0;
    M_AXIS_tlast  = 1'b0;
    if (busy) begin
      M_AXIS_tvalid = 1'b1;
      M_AXIS_tdata  = sreg[IN_WIDTH-1 -: OUT_WIDTH];
`ifdef TRACE_SERIALIZER_SEQ_HEADER_EN
      if (idx == '0) M_AXIS_tdata = {16'hA5C3, hdr_seq, {(OUT_WIDTH-48){1'b0}}};
`endif
      M_AXIS_tlast  = lflag & at_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg      <= '0;
      idx       <= '0;
      lflag     <= 1'b0;
      pkt_count <= '0;
`ifdef TRACE_SERIALIZER_SEQ_HEADER_EN
      seq       <= '0;
      hdr_seq   <= '0;
`endif
    end else begin
      if (out_hs) begin
        if (!at_last) begin
`ifdef TRACE_SERIALIZER_SEQ_HEADER_EN
          // Header occupies beat 0, so the first data slice is not shifted out yet.
          if (idx != '0) sreg <= sreg << OUT_WIDTH;
`else
          sreg <= sreg << OUT_WIDTH;
`endif
          idx <= idx + 1'b1;
        end else begin
          pkt_count <= pkt_count + 32'd1;
        end
      end
      if (in_hs) begin
        sreg  <= S_AXIS_tdata;
        lflag <= S_AXIS_tlast;
        idx   <= '0;
`ifdef TRACE_SERIALIZER_SEQ_HEADER_EN
        hdr_seq <= seq;
        seq     <= seq + 32'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_trace_stream_serializer.sv
// Randomized bench for trace_stream_serializer against a queue-based beat model.
// Honors TRACE_SERIALIZER_SEQ_HEADER_EN to expect the header beat.
module tb_trace_stream_serializer;

  localparam int IW = 1024;
  localparam int OW = 64;
  localparam int NB = IW / OW;
`ifdef TRACE_SERIALIZER_SEQ_HEADER_EN
  localparam int PB = NB + 1;
`else
  localparam int PB = NB;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          S_AXIS_tvalid;
  logic          S_AXIS_tready;
  logic [IW-1:0] S_AXIS_tdata;
  logic          S_AXIS_tlast;
  logic          M_AXIS_tvalid;
  logic          M_AXIS_tready;
  logic [OW-1:0] M_AXIS_tdata;
  logic          M_AXIS_tlast;
  logic [31:0]   pkt_count;
  logic          busy;

  trace_stream_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
    .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tlast(S_AXIS_tlast),
    .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tready(M_AXIS_tready),
    .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tlast(M_AXIS_tlast),
    .pkt_count(pkt_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
    bit            eop;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] exp_pkts = '0;
  logic [31:0] exp_seq  = '0;
  int          errors   = 0;
  int          checks   = 0;

  // Reference: a packet becomes (header) + slices from most to least significant.
  function automatic void push_packet(input logic [IW-1:0] d, input logic tl);
    beat_t b;
`ifdef TRACE_SERIALIZER_SEQ_HEADER_EN
    b.data = {16'hA5C3, exp_seq, {(OW-48){1'b0}}};
    b.last = 1'b0;
    b.eop  = 1'b0;
    exp_q.push_back(b);
    exp_seq = exp_seq + 32'd1;
`endif
    for (int k = NB - 1; k >= 0; k--) begin
      b.data = d[k*OW +: OW];
      b.last = tl && (k == 0);
      b.eop  = (k == 0);
      exp_q.push_back(b);
    end
  endfunction

  function automatic logic [IW-1:0] rand_pkt();
    logic [IW-1:0] p;
    for (int i = 0; i < IW / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  function automatic logic [IW-1:0] index_pkt();
    logic [IW-1:0] p;
    for (int k = 0; k < NB; k++) p[k*OW +: OW] = OW'(k);
    return p;
  endfunction

  // Samples settled outputs before the edge, then advances past it.
  task automatic step(output bit mv, output bit ohs, output logic [OW-1:0] od,
                      output logic ol, output bit ihs);
    @(negedge clk);
    mv  = (M_AXIS_tvalid === 1'b1);
    ohs = mv && (M_AXIS_tready === 1'b1) && (rst_n === 1'b1);
    ihs = (S_AXIS_tvalid === 1'b1) && (S_AXIS_tready === 1'b1);
    od  = M_AXIS_tdata;
    ol  = M_AXIS_tlast;
    @(posedge clk);
    if (ihs) push_packet(S_AXIS_tdata, S_AXIS_tlast);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; S_AXIS_tvalid = 1'b0; S_AXIS_tdata = '0; S_AXIS_tlast = 1'b0;
    M_AXIS_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (M_AXIS_tvalid !== 1'b0 || M_AXIS_tlast !== 1'b0 || M_AXIS_tdata !== '0) begin
      errors++;
      $display("FAIL reset_m_out: got valid=%b last=%b data=%h, required 0 0 0", M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata);
    end
    checks++;
    if (pkt_count !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got pkt_count=%0d busy=%b, required 0 0", pkt_count, busy);
    end
    checks++;
    if (S_AXIS_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_s_tready: got %b, required 0", S_AXIS_tready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (S_AXIS_tready !== 1'b1) begin
      errors++;
      $display("FAIL release_s_tready: got %b, required 1", S_AXIS_tready);
    end
  endtask

  task automatic test_single();
    bit mv, ohs, ihs; logic [OW-1:0] od; logic ol; beat_t e;
    int nb = 0, cyc = 0;
    S_AXIS_tvalid = 1'b1; S_AXIS_tdata = index_pkt(); S_AXIS_tlast = 1'b0; M_AXIS_tready = 1'b1;
    step(mv, ohs, od, ol, ihs);
    S_AXIS_tvalid = 1'b0;
    checks++;
    if (!ihs || M_AXIS_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: got accept=%b m_tvalid=%b, required 1 1", ihs, M_AXIS_tvalid);
    end
    while (exp_q.size() > 0 && cyc < 4 * PB) begin
      step(mv, ohs, od, ol, ihs);
      cyc++;
      if (ohs) begin
        nb++;
        checks++;
        e = exp_q.pop_front();
        if (e.eop) exp_pkts++;
        if (od !== e.data || ol !== e.last) begin
          errors++;
          $display("FAIL single_beat: got data=%h last=%b, required data=%h last=%b", od, ol, e.data, e.last);
        end
      end
    end
    checks++;
    if (nb != PB || cyc != PB || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_timing: got %0d beats in %0d cycles, required %0d in %0d", nb, cyc, PB, PB);
    end
    checks++;
    if (pkt_count !== exp_pkts || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_count: got pkt_count=%0d busy=%b, required %0d 0", pkt_count, busy, exp_pkts);
    end
  endtask

  task automatic test_back_to_back();
    bit mv, ohs, ihs; logic [OW-1:0] od; logic ol; beat_t e;
    int n = 0, nb = 0, cyc = 0, first_b = -1, last_b = -1;
    int hs_cyc[3];
    S_AXIS_tvalid = 1'b1; S_AXIS_tdata = rand_pkt(); S_AXIS_tlast = 1'($urandom_range(0, 1));
    M_AXIS_tready = 1'b1;
    while ((n < 3 || exp_q.size() > 0) && cyc < 10 * PB) begin
      step(mv, ohs, od, ol, ihs);
      if (ihs) begin
        hs_cyc[n] = cyc;
        n++;
        if (n < 3) begin
          S_AXIS_tdata = rand_pkt(); S_AXIS_tlast = 1'($urandom_range(0, 1));
        end else S_AXIS_tvalid = 1'b0;
      end
      if (ohs) begin
        nb++;
        if (first_b < 0) first_b = cyc;
        last_b = cyc;
        checks++;
        e = exp_q.pop_front();
        if (e.eop) exp_pkts++;
        if (od !== e.data || ol !== e.last) begin
          errors++;
          $display("FAIL b2b_beat: got data=%h last=%b, required data=%h last=%b", od, ol, e.data, e.last);
        end
      end
      cyc++;
    end
    checks++;
    if (n != 3 || hs_cyc[1] != PB || hs_cyc[2] != 2 * PB) begin
      errors++;
      $display("FAIL b2b_s_tready: got %0d loads at %0d,%0d, required 3 at %0d,%0d", n, hs_cyc[1], hs_cyc[2], PB, 2 * PB);
    end
    checks++;
    if (nb != 3 * PB || last_b - first_b + 1 != 3 * PB) begin
      errors++;
      $display("FAIL b2b_gapless: got %0d beats over %0d cycles, required %0d over %0d", nb, last_b - first_b + 1, 3 * PB, 3 * PB);
    end
    checks++;
    if (pkt_count !== exp_pkts) begin
      errors++;
      $display("FAIL b2b_count: got %0d, required %0d", pkt_count, exp_pkts);
    end
  endtask

  task automatic test_backpressure();
    bit mv, ohs, ihs, hold = 0; logic [OW-1:0] od, hd; logic ol, hl; beat_t e;
    int cyc = 0;
    S_AXIS_tvalid = 1'b1; S_AXIS_tdata = rand_pkt(); S_AXIS_tlast = 1'b1; M_AXIS_tready = 1'b1;
    step(mv, ohs, od, ol, ihs);
    S_AXIS_tvalid = 1'b0;
    while (exp_q.size() > 0 && cyc < 6 * PB) begin
      M_AXIS_tready = (cyc % 2 == 0);
      step(mv, ohs, od, ol, ihs);
      cyc++;
      if (hold) begin
        checks++;
        if (!mv || od !== hd || ol !== hl) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b data=%h, required 1 %h", mv, od, hd);
        end
      end
      hold = mv && !M_AXIS_tready; hd = od; hl = ol;
      if (ohs) begin
        checks++;
        e = exp_q.pop_front();
        if (e.eop) exp_pkts++;
        if (od !== e.data || ol !== e.last) begin
          errors++;
          $display("FAIL bp_beat: got data=%h last=%b, required data=%h last=%b", od, ol, e.data, e.last);
        end
      end
    end
    M_AXIS_tready = 1'b1;
    checks++;
    if (cyc != 2 * PB - 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_duration: got %0d cycles, required %0d", cyc, 2 * PB - 1);
    end
    checks++;
    if (pkt_count !== exp_pkts) begin
      errors++;
      $display("FAIL bp_count: got %0d, required %0d", pkt_count, exp_pkts);
    end
  endtask

  task automatic test_tlast();
    bit mv, ohs, ihs; logic [OW-1:0] od; logic ol; beat_t e;
    int n = 0, nb = 0, cyc = 0, tl_n = 0, tl_at = -1;
    S_AXIS_tvalid = 1'b1; S_AXIS_tdata = rand_pkt(); S_AXIS_tlast = 1'b0; M_AXIS_tready = 1'b1;
    while ((n < 2 || exp_q.size() > 0) && cyc < 8 * PB) begin
      step(mv, ohs, od, ol, ihs);
      cyc++;
      if (ihs) begin
        n++;
        if (n < 2) begin S_AXIS_tdata = rand_pkt(); S_AXIS_tlast = 1'b1; end
        else S_AXIS_tvalid = 1'b0;
      end
      if (ohs) begin
        if (ol === 1'b1) begin tl_n++; tl_at = nb; end
        nb++;
        checks++;
        e = exp_q.pop_front();
        if (e.eop) exp_pkts++;
        if (od !== e.data || ol !== e.last) begin
          errors++;
          $display("FAIL tlast_beat: got data=%h last=%b, required data=%h last=%b", od, ol, e.data, e.last);
        end
      end
    end
    S_AXIS_tlast = 1'b0;
    checks++;
    if (tl_n != 1 || tl_at != 2 * PB - 1) begin
      errors++;
      $display("FAIL tlast_position: got %0d tlast beats at %0d, required 1 at %0d", tl_n, tl_at, 2 * PB - 1);
    end
  endtask

  task automatic test_reset_mid();
    bit mv, ohs, ihs; logic [OW-1:0] od; logic ol; beat_t e;
    int cyc = 0;
    S_AXIS_tvalid = 1'b1; S_AXIS_tdata = rand_pkt(); S_AXIS_tlast = 1'b1; M_AXIS_tready = 1'b1;
    step(mv, ohs, od, ol, ihs);
    S_AXIS_tvalid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(mv, ohs, od, ol, ihs);
      if (ohs) begin
        checks++;
        e = exp_q.pop_front();
        if (od !== e.data || ol !== e.last) begin
          errors++;
          $display("FAIL abort_pre_beat: got data=%h, required %h", od, e.data);
        end
      end
    end
    rst_n = 1'b0;
    step(mv, ohs, od, ol, ihs);
    exp_q.delete(); exp_pkts = '0; exp_seq = '0;
    checks++;
    if (M_AXIS_tvalid !== 1'b0 || pkt_count !== 32'd0 || busy !== 1'b0 || S_AXIS_tready !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: got valid=%b pkt_count=%0d busy=%b s_ready=%b, required 0 0 0 0", M_AXIS_tvalid, pkt_count, busy, S_AXIS_tready);
    end
    rst_n = 1'b1;
    S_AXIS_tvalid = 1'b1; S_AXIS_tdata = index_pkt(); S_AXIS_tlast = 1'b0;
    step(mv, ohs, od, ol, ihs);
    S_AXIS_tvalid = 1'b0;
    while (exp_q.size() > 0 && cyc < 4 * PB) begin
      step(mv, ohs, od, ol, ihs);
      cyc++;
      if (ohs) begin
        checks++;
        e = exp_q.pop_front();
        if (e.eop) exp_pkts++;
        if (od !== e.data || ol !== e.last) begin
          errors++;
          $display("FAIL abort_post_beat: got data=%h last=%b, required data=%h last=%b", od, ol, e.data, e.last);
        end
      end
    end
    checks++;
    if (pkt_count !== 32'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_post_count: got %0d (pending %0d), required 1 (pending 0)", pkt_count, exp_q.size());
    end
  endtask

  task automatic test_random();
    bit mv, ohs, ihs, hold = 0; logic [OW-1:0] od, hd; logic ol, hl; beat_t e;
    int loaded = 0, cyc = 0;
    S_AXIS_tvalid = 1'b0;
    while ((loaded < 8 || exp_q.size() > 0) && cyc < 2000) begin
      if (!S_AXIS_tvalid && loaded < 8 && $urandom_range(0, 2) == 0) begin
        S_AXIS_tvalid = 1'b1; S_AXIS_tdata = rand_pkt(); S_AXIS_tlast = 1'($urandom_range(0, 1));
      end
      M_AXIS_tready = ($urandom_range(0, 3) != 0);
      step(mv, ohs, od, ol, ihs);
      cyc++;
      if (ihs) begin loaded++; S_AXIS_tvalid = 1'b0; end
      if (hold) begin
        checks++;
        if (!mv || od !== hd || ol !== hl) begin
          errors++;
          $display("FAIL rand_hold: got valid=%b data=%h, required 1 %h", mv, od, hd);
        end
      end
      hold = mv && !M_AXIS_tready; hd = od; hl = ol;
      if (ohs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra_beat: got data=%h, required no beat", od);
        end else begin
          e = exp_q.pop_front();
          if (e.eop) exp_pkts++;
          if (od !== e.data || ol !== e.last) begin
            errors++;
            $display("FAIL rand_beat: got data=%h last=%b, required data=%h last=%b", od, ol, e.data, e.last);
          end
        end
      end
    end
    checks++;
    if (loaded != 8 || exp_q.size() != 0 || pkt_count !== exp_pkts) begin
      errors++;
      $display("FAIL rand_done: got loaded=%0d pending=%0d pkt_count=%0d, required 8 0 %0d", loaded, exp_q.size(), pkt_count, exp_pkts);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_tlast();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trace_stream_serializer.md
# trace_stream_serializer

Downstream neighbour of the continuous monitoring system. It accepts the wide trace packets from the monitor's AXI-Stream master and breaks each one into a fixed number of narrower AXI-Stream beats for the DMA/FIFO interconnect. Packet boundaries, `tlast` and backpressure are preserved. In the default configuration the block does not add bubbles between packets.

## Interface
Parameters:
- `IN_WIDTH`, 1024: width of the input packet. It must be an integer multiple of `OUT_WIDTH`; any other value is an elaboration error.
- `OUT_WIDTH`, 64: width of each output beat.
- Derived: `BEATS = IN_WIDTH / OUT_WIDTH` (16 by default).

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `S_AXIS_tvalid`, in, 1: input packet valid.
- `S_AXIS_tready`, out, 1: serializer can accept a packet.
- `S_AXIS_tdata`, in, `IN_WIDTH`: input packet.
- `S_AXIS_tlast`, in, 1: end of a DMA transfer.
- `M_AXIS_tvalid`, out, 1: output beat valid.
- `M_AXIS_tready`, in, 1: downstream ready.
- `M_AXIS_tdata`, out, `OUT_WIDTH`: output beat.
- `M_AXIS_tlast`, out, 1: asserted on the final beat of a packet whose input `tlast` was set.
- `pkt_count`, out, 32: number of packets fully emitted, wrapping modulo 2^32.
- `busy`, out, 1: high while in `SEND`.

## Operation
- State machine with two states: `IDLE` and `SEND`. Internal registers: a shift register `sreg` (`IN_WIDTH` bits), a beat index `idx` (`$clog2(BEATS+1)` bits) and a captured-tlast flag `lflag`.
- Input handshake (`S_AXIS_tvalid & S_AXIS_tready`) does the following:
  - loads `sreg <= S_AXIS_tdata`, `lflag <= S_AXIS_tlast`, `idx <= 0`;
  - moves the state machine to `SEND`.
- `S_AXIS_tready` is combinational: `rst_n & (state==IDLE | (state==SEND & idx==LAST & M_AXIS_tready))`.
  - `LAST` is `BEATS-1`, or `BEATS` when the header is enabled.
  - The second term lets a new packet load on the same cycle the final beat is accepted.
- `SEND` state:
  - `M_AXIS_tvalid = 1`.
  - `M_AXIS_tdata` is `sreg[IN_WIDTH-1 -: OUT_WIDTH]`, so the most significant slice (instr field) goes first.
  - `M_AXIS_tlast = lflag & (idx==LAST)`.
- Output handshake in `SEND`:
  - If `idx != LAST`: `sreg <= sreg << OUT_WIDTH`, `idx <= idx+1`.
  - If `idx == LAST`: `pkt_count <= pkt_count+1`. The next state is `SEND` with a new packet loaded if an input handshake happens on the same cycle, otherwise `IDLE`.
- Without an output handshake, `M_AXIS_tdata`, `M_AXIS_tlast` and `idx` hold their values. AXI rule: once `tvalid` is raised it is not dropped until `tready`.
- `IDLE` state: `M_AXIS_tvalid=0`, `M_AXIS_tdata=0`, `M_AXIS_tlast=0`.
- Reset mid-packet: the partial packet is discarded with no further beats. The block returns to `IDLE`, clears `sreg`, `idx`, `lflag` and `pkt_count`, and holds `S_AXIS_tready=0` while `rst_n=0`.
- Output values during and after reset: `M_AXIS_tvalid=0`, `M_AXIS_tdata=0`, `M_AXIS_tlast=0`, `pkt_count=0`, `busy=0`, `S_AXIS_tready=0`. `S_AXIS_tready` rises to 1 on the first cycle with `rst_n=1`.

## Timing
- Latency: an input handshake at edge N makes the first beat valid in cycle N+1 (registered output, no combinational path from S to M data).
- Throughput with `M_AXIS_tready` held at 1 and input always valid: one beat per cycle, one packet per `LAST+1` cycles, no idle cycles between packets.
- `S_AXIS_tready` depends combinationally on `M_AXIS_tready` only during the final-beat cycle.
- `pkt_count` updates on the edge that accepts the final beat.

## Configuration
- `TRACE_SERIALIZER_SEQ_HEADER_EN` defined: each packet is preceded by a header beat.
  - Header layout: `{16'hA5C3, seq[31:0], {(OUT_WIDTH-48){1'b0}}}`.
  - `seq` is a 32-bit counter that resets to 0, increments on each input handshake and wraps at 2^32.
  - With the header, `LAST = BEATS` and each packet is `BEATS+1` beats. The header is beat 0; `tlast` never appears on the header beat.
- Macro undefined: no header, `LAST = BEATS-1`, and the `seq` logic is absent.

## Test plan
- Single packet, defaults, `tdata = {16{64'h0..0F}}` pattern with slice k = k, `tready=1` → 16 beats on consecutive cycles carrying 15,14,…,0. `tlast` is set only if input `tlast` is set; `pkt_count=1`.
- Back-to-back: 3 packets with `S_AXIS_tvalid` held high and `tready=1` → 48 beats with no gap; `S_AXIS_tready` pulses on cycles 16 and 32 relative to the start; `pkt_count=3`.
- Backpressure: toggle `M_AXIS_tready` 1/0 every cycle → `tdata` is stable across stall cycles, no beat lost or duplicated, and the packet completes in 31 cycles.
- Input `tlast=1` on the 2nd of 2 packets → `M_AXIS_tlast` is set only on beat 31 overall.
- Reset asserted at beat 7 → `M_AXIS_tvalid=0` the next cycle, `pkt_count=0`; the next packet starts at slice 15 with no residue from the aborted packet.
- With `TRACE_SERIALIZER_SEQ_HEADER_EN`: 2 packets → beats 0 and 17 are `64'hA5C3_00000000_0000` and `64'hA5C3_00000001_0000`, 34 beats in total.
